// File: rtl/float2int_pkg.sv
// float2int_pkg: shared widths, FSM state type and shift-count helper for the
// 7-bit minifloat (3-bit exponent, 4-bit mantissa) to 11-bit integer decoder.
// The field widths are fixed here. INT_W = MANT_W + 2**EXP_W - 1 is the only
// supported combination.
package float2int_pkg;

    localparam int unsigned EXP_W   = 3;
    localparam int unsigned MANT_W  = 4;
    localparam int unsigned FLOAT_W = EXP_W + MANT_W;
    localparam int unsigned SIG_W   = MANT_W + 1;
    localparam int unsigned INT_W   = MANT_W + (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Left shift applied to the significand. exp 0 is subnormal and uses no
    // shift, which makes exp 0 and exp 1 share the same scale.
    function automatic logic [EXP_W-1:0] init_shift(input logic [EXP_W-1:0] exp);
        return (exp == '0) ? '0 : exp - 1'b1;
    endfunction

endpackage

// File: rtl/f2i_unpack.sv
// f2i_unpack: combinational field split for the minifloat decoder.
//   float_i : {exp, mant}
//   sig_o   : significand with the hidden bit inserted (iterative build)
//   cnt_o   : number of left shifts still to apply (iterative build)
//   value_o : fully shifted integer (only when FLOAT2INT_FAST_EN is defined)
module f2i_unpack
    import float2int_pkg::*;
(
    input  logic [FLOAT_W-1:0] float_i,
`ifdef FLOAT2INT_FAST_EN
    output logic [INT_W-1:0]   value_o
`else
    output logic [SIG_W-1:0]   sig_o,
    output logic [EXP_W-1:0]   cnt_o
`endif
);

    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic [SIG_W-1:0]  sig;
    logic [EXP_W-1:0]  cnt;

    assign exp  = float_i[FLOAT_W-1:MANT_W];
    assign mant = float_i[MANT_W-1:0];
    // The hidden bit is present for every normal exponent.
    assign sig  = {(exp != '0), mant};
    assign cnt  = init_shift(exp);

`ifdef FLOAT2INT_FAST_EN
    assign value_o = INT_W'(sig) << cnt;
`else
    assign sig_o = sig;
    assign cnt_o = cnt;
`endif

endmodule

// File: rtl/float2int_seq.sv
// float2int_seq: sequential minifloat-to-integer converter with valid/ready
// handshakes on both sides.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, in_float = {exp[2:0], mant[3:0]}
//   out_valid/out_ready  : output handshake, out_int = 11-bit result
//   busy                 : registered, high whenever the FSM is not idle
// Build option FLOAT2INT_FAST_EN: barrel-shift in the accept cycle and go
// straight to DONE. Without it, one bit is shifted per cycle in SHIFT.
module float2int_seq
    import float2int_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLOAT_W-1:0] in_float,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INT_W-1:0]   out_int,
    output logic               busy
);

    state_e           state_q, state_d;
    logic [INT_W-1:0] out_q, out_d;
    logic             busy_q;

`ifdef FLOAT2INT_FAST_EN
    logic [INT_W-1:0] value;

    f2i_unpack u_unpack (
        .float_i (in_float),
        .value_o (value)
    );
`else
    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] init_cnt;
    logic [INT_W-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;

    f2i_unpack u_unpack (
        .float_i (in_float),
        .sig_o   (sig),
        .cnt_o   (init_cnt)
    );
`endif

    // out_q is written only on entry to DONE, so it holds the last result
    // while a new conversion is shifting.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifndef FLOAT2INT_FAST_EN
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef FLOAT2INT_FAST_EN
                    state_d = StDone;
                    out_d   = value;
`else
                    acc_d = INT_W'(sig);
                    cnt_d = init_cnt;
                    if (init_cnt == '0) begin
                        state_d = StDone;
                        out_d   = INT_W'(sig);
                    end else begin
                        state_d = StShift;
                    end
`endif
                end
            end
`ifndef FLOAT2INT_FAST_EN
            StShift: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == EXP_W'(1)) begin
                    state_d = StDone;
                    out_d   = acc_q << 1;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            busy_q  <= 1'b0;
`ifndef FLOAT2INT_FAST_EN
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= (state_d != StIdle);
`ifndef FLOAT2INT_FAST_EN
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_int   = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_float2int_seq.sv
// Directed testbench for float2int_seq. Latency is counted in clock edges from
// the accepting edge (inclusive) up to the edge after which out_valid is high.
module tb_float2int_seq;

`ifdef FLOAT2INT_FAST_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_float;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_int;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float2int_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_float  (in_float),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Decode reference: subnormal for exp 0, hidden bit and shift otherwise.
    function automatic logic [10:0] ref_val(input logic [6:0] f);
        logic [2:0] e;
        logic [3:0] m;
        e = f[6:4];
        m = f[3:0];
        if (e == 3'd0) return {7'd0, m};
        return 11'({1'b1, m}) << (e - 3'd1);
    endfunction

    function automatic int ref_lat(input logic [6:0] f);
        if (Fast) return 1;
        return (f[6:4] <= 3'd1) ? 1 : int'(f[6:4]);
    endfunction

    // Present f and hold it until the accepting edge.
    task automatic start(input logic [6:0] f);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("start_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_float = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int first, output int lat);
        lat = first;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic convert(input logic [6:0] f, input logic [10:0] want, input int want_lat,
                           input string tag, output logic [10:0] got);
        int lat;
        start(f);
        wait_done(1, lat);
        got = out_int;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_int), 32'(want));
        chk({tag, "_lat"}, lat, want_lat);
        tick();
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] got;
        logic [10:0] prev;
        int          lat;
        logic        seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_float  = 7'h00;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_int", 32'(out_int), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors, values worked out by hand.
        convert(7'h00, 11'h000, 1, "zero", got);
        convert(7'h15, 11'h015, 1, "e1m5", got);                 // 21
        convert(7'h3A, 11'h068, Fast ? 1 : 3, "e3mA", got);      // 26 << 2
        convert(7'h7F, 11'h7C0, Fast ? 1 : 7, "max", got);       // 31 << 6
        convert(7'h0F, 11'h00F, 1, "sub_top", got);
        convert(7'h10, 11'h010, 1, "norm_low", got);

        // Backpressure: 0x4C is exp 4, mant 0xC -> 28 << 3 = 0x0E0.
        out_ready = 1'b0;
        start(7'h4C);
        wait_done(1, lat);
        chk("bp_lat", lat, Fast ? 1 : 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_int), 32'h0E0);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_busy", 32'(busy), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset while shifting 0x70; the pending result must never show up.
        start(7'h70);
        chk("mid_busy", 32'(busy), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_int", 32'(out_int), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_rst_no_stale", 32'(seen), 32'd0);

        // Ignored input: 0x11 pulsed while 0x60 is in flight (16 << 5 = 0x200).
        out_ready = 1'b0;
        start(7'h60);
        in_valid = 1'b1;
        in_float = 7'h11;
        tick();
        in_valid = 1'b0;
        wait_done(2, lat);
        chk("ign_valid", 32'(out_valid), 32'd1);
        chk("ign_data", 32'(out_int), 32'h200);
        out_ready = 1'b1;
        tick();
        chk("ign_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("ign_not_consumed", 32'(seen), 32'd0);

        // Full code sweep against the reference, with a monotonicity check.
        prev = '0;
        for (int c = 0; c < 128; c++) begin
            logic [6:0] f;
            f = 7'(c);
            convert(f, ref_val(f), ref_lat(f), $sformatf("code%0h", c), got);
            if (c > 0) chk($sformatf("mono%0h", c), 32'(got >= prev), 32'd1);
            prev = got;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
